// File: rtl/adc_sar_pkg.sv
// Shared types and constants for the SAR ADC control slice.
// The ADC_SAR_AVG_EN build of adc_sar_control uses the averaging constants below.
package adc_sar_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAMPLE  = 2'd1,
      CONVERT = 2'd2,
      DONE    = 2'd3
   } sar_state_t;

   localparam int SAMPLE_CNT_W = 4;

   // Four conversions are averaged, so the sum is divided by a 2-bit right shift
   localparam int AVG_DEPTH = 4;
   localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/adc_sar_bit_register.sv
// Decided-bit store and trial pointer for the successive-approximation search.
// The pointer walks from MSB to LSB; final_word is the stored word with the current bit resolved.
module adc_sar_bit_register #(
   parameter int RESOLUTION = 12
) (
   input  logic                  clk_dig,
   input  logic                  clear,
   input  logic                  load,
   input  logic                  step,
   input  logic                  comp_in,
   output logic [RESOLUTION-1:0] dac_word,
   output logic [RESOLUTION-1:0] final_word,
   output logic                  last_bit
);

   localparam int PTR_W = $clog2(RESOLUTION);

   logic [RESOLUTION-1:0] bits_q;
   logic [PTR_W-1:0]      ptr_q;
   logic [RESOLUTION-1:0] trial_mask;

   // Bits below the pointer are always zero, so OR-ing the mask forms the trial word
   always_comb begin
      trial_mask = {{(RESOLUTION-1){1'b0}}, 1'b1} << ptr_q;
      dac_word   = bits_q | trial_mask;
      final_word = comp_in ? (bits_q | trial_mask) : (bits_q & ~trial_mask);
      last_bit   = (ptr_q == '0);
   end

   always_ff @(posedge clk_dig) begin
      if (clear) begin
         bits_q <= '0;
         ptr_q  <= '0;
      end else if (load) begin
         bits_q <= '0;
         ptr_q  <= PTR_W'(RESOLUTION-1);
      end else if (step) begin
         bits_q <= final_word;
         if (ptr_q != '0)
            ptr_q <= ptr_q - PTR_W'(1);
      end
   end

endmodule

// File: rtl/adc_sar_control.sv
// SAR ADC conversion FSM: sample, resolve one bit per clk_dig cycle, publish the result.
// Define ADC_SAR_AVG_EN to average four back-to-back conversions per start request.
module adc_sar_control
   import adc_sar_pkg::*;
#(
   parameter int RESOLUTION    = 12,
   parameter int SAMPLE_CYCLES = 2
) (
   input  logic                  clk_dig,
   input  logic                  rst_n,
   input  logic                  start_conv,
   input  logic                  comp_in,
   output logic                  ena_out,
   output logic                  sample,
   output logic [RESOLUTION-1:0] dac_word,
   output logic [RESOLUTION-1:0] result,
   output logic                  conv_done,
   output logic                  busy
);

   sar_state_t              state_q, state_d;
   logic                    start_q;
   logic                    start_rise;
   logic [SAMPLE_CNT_W-1:0] sample_cnt_q;
   logic [RESOLUTION-1:0]   result_q;
   logic                    reg_load, reg_step;
   logic [RESOLUTION-1:0]   trial_word, final_word;
   logic                    last_bit;
   logic                    conv_end;

`ifdef ADC_SAR_AVG_EN
   localparam int AVG_CNT_W = $clog2(AVG_DEPTH);

   logic [AVG_CNT_W-1:0]  avg_cnt_q;
   logic [RESOLUTION+1:0] acc_q, acc_sum;
`endif

   assign start_rise = start_conv & ~start_q;
   assign conv_end   = (state_q == CONVERT) && last_bit;
   assign result     = result_q;

   adc_sar_bit_register #(
      .RESOLUTION (RESOLUTION)
   ) u_bit_register (
      .clk_dig    (clk_dig),
      .clear      (~rst_n),
      .load       (reg_load),
      .step       (reg_step),
      .comp_in    (comp_in),
      .dac_word   (trial_word),
      .final_word (final_word),
      .last_bit   (last_bit)
   );

   always_comb begin
      state_d   = state_q;
      reg_load  = 1'b0;
      reg_step  = 1'b0;
      ena_out   = 1'b0;
      sample    = 1'b0;
      busy      = 1'b0;
      conv_done = 1'b0;
      dac_word  = '0;
      case (state_q)
         IDLE: begin
            if (start_rise)
               state_d = SAMPLE;
         end
         SAMPLE: begin
            sample  = 1'b1;
            ena_out = 1'b1;
            busy    = 1'b1;
            if (sample_cnt_q == '0) begin
               state_d  = CONVERT;
               reg_load = 1'b1;
            end
         end
         CONVERT: begin
            ena_out  = 1'b1;
            busy     = 1'b1;
            dac_word = trial_word;
            reg_step = 1'b1;
            if (last_bit)
               state_d = DONE;
         end
         DONE: begin
            ena_out = 1'b1;
            busy    = 1'b1;
`ifdef ADC_SAR_AVG_EN
            // The count has wrapped to zero once the last of the four conversions ended
            conv_done = (avg_cnt_q == '0);
            state_d   = (avg_cnt_q == '0) ? IDLE : SAMPLE;
`else
            conv_done = 1'b1;
            state_d   = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_dig) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         start_q      <= 1'b0;
         sample_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_conv;
         if (state_d == SAMPLE && state_q != SAMPLE)
            sample_cnt_q <= SAMPLE_CNT_W'(SAMPLE_CYCLES-1);
         else if (state_q == SAMPLE && sample_cnt_q != '0)
            sample_cnt_q <= sample_cnt_q - SAMPLE_CNT_W'(1);
      end
   end

`ifdef ADC_SAR_AVG_EN
   assign acc_sum = acc_q + {2'b00, final_word};

   always_ff @(posedge clk_dig) begin
      if (!rst_n) begin
         result_q  <= '0;
         acc_q     <= '0;
         avg_cnt_q <= '0;
      end else if (conv_end) begin
         avg_cnt_q <= avg_cnt_q + AVG_CNT_W'(1);
         if (avg_cnt_q == AVG_CNT_W'(AVG_DEPTH-1)) begin
            result_q <= acc_sum[AVG_SHIFT +: RESOLUTION];
            acc_q    <= '0;
         end else begin
            acc_q <= acc_sum;
         end
      end
   end
`else
   always_ff @(posedge clk_dig) begin
      if (!rst_n)
         result_q <= '0;
      else if (conv_end)
         result_q <= final_word;
   end
`endif

endmodule

// File: doc/adc_sar_control.md
# adc_sar_control

Successive-approximation control FSM for the SKY130 SAR ADC, clocked by `clk_dig` from the comparator-loop clock generator. It detects a conversion request, drives the sample switch and capacitor-DAC trial word, and resolves one bit per `clk_dig` cycle from the comparator decision. It holds `ena_out`, which feeds the clock generator's `ena_in`, so the comparator loop keeps running until the conversion is finished. It then publishes the result with a one-cycle done strobe.

## Interface
- `RESOLUTION`, default 12: number of result bits and DAC control bits. Legal range is 2..16.
- `SAMPLE_CYCLES`, default 2: number of `clk_dig` cycles the sample switch stays closed. Legal range is 1..15.

Clock and reset are decided: one clock, and reset is synchronous and active-low.

- `clk_dig`, in, 1: block clock. All logic is rising-edge.
- `rst_n`, in, 1: synchronous active-low reset.
- `start_conv`, in, 1: conversion request. Its rising edge triggers a conversion; it is already synchronous to `clk_dig`.
- `comp_in`, in, 1: comparator decision for the current trial word. 1 means Vin ≥ Vdac, so the trial bit is kept.
- `ena_out`, out, 1: keeps the clock loop running; connects to the clock generator's `ena_in`.
- `sample`, out, 1: sample/track switch control.
- `dac_word`, out, RESOLUTION: capacitor-DAC trial word.
- `result`, out, RESOLUTION: last completed conversion result.
- `conv_done`, out, 1: one-cycle strobe marking that `result` has been updated.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- Reset values: all outputs are 0, the state is IDLE and the start-edge history register is 0.
- The start-edge history register samples `start_conv` on every edge. A rising edge is `start_conv & ~start_q`.
- States and transitions:
  - IDLE → SAMPLE on a rising edge of `start_conv`.
  - SAMPLE → CONVERT after SAMPLE_CYCLES cycles.
  - CONVERT → DONE after RESOLUTION cycles.
  - DONE → IDLE after 1 cycle.
- IDLE: `ena_out`=0, `sample`=0, `dac_word`=0.
- SAMPLE: `sample`=1, `ena_out`=1, `dac_word`=0. A 4-bit down-counter times this phase.
- CONVERT: bit index `i` runs from RESOLUTION-1 down to 0.
  - `dac_word` = decided bits OR (1<<i).
  - At the end of the cycle, bit `i` is set to `comp_in` and `i` is decremented.
  - `comp_in` is ignored in every other state.
- DONE: the final word is loaded into `result`, `conv_done`=1 and `ena_out`=1. `ena_out` drops on return to IDLE.
- Rising edges of `start_conv` outside IDLE are dropped, not queued.
- Holding `start_conv` high does not retrigger; it must fall and rise again.
- `result` holds its value until the next DONE. It is cleared only by reset.
- Reset in any state: all outputs return to their reset values on that edge, and any partial conversion is discarded.

## Timing
- Let edge n be the edge at which the rising start edge is detected.
  - `sample` and `busy` are high from edge n to edge n+SAMPLE_CYCLES.
  - Bit RESOLUTION-1 is tried in cycle n+SAMPLE_CYCLES and bit 0 in cycle n+SAMPLE_CYCLES+RESOLUTION-1.
  - `conv_done` and the updated `result` appear after edge n+SAMPLE_CYCLES+RESOLUTION.
  - `conv_done` is high for exactly one cycle. With the defaults, that is after edge n+14.
- The comparator decision must settle within one `clk_dig` period of the `dac_word` update. The clock generator's comparator/`clk_dig` delay chains guarantee this.
- Throughput: one conversion per SAMPLE_CYCLES+RESOLUTION+2 cycles at minimum, because IDLE costs one cycle.

## Configuration
- `ADC_SAR_AVG_EN` defined:
  - DONE does not return to IDLE. It loops back to SAMPLE until 4 conversions have completed, tracked by a 2-bit count.
  - Each conversion word is added into a RESOLUTION+2 bit accumulator.
  - On the 4th DONE, `result` = accumulator[RESOLUTION+1:2] (truncated) and `conv_done` pulses once.
  - `ena_out` and `busy` stay high across all four conversions.
  - Reset clears the accumulator and the count.
- `ADC_SAR_AVG_EN` undefined: single conversion per start, as described above. The accumulator and count logic are not present.

## Structure
- Package `adc_sar_pkg` holds:
  - the state enum (IDLE, SAMPLE, CONVERT, DONE);
  - the sample-counter width constant (4);
  - the averaging depth constant (4) and its shift (2).
- One sub-module, `adc_sar_bit_register`. It holds the decided bits and the trial pointer, and provides load/step/clear controls plus a `dac_word` output. The FSM and the averaging logic live in `adc_sar_control`.

## Test plan
- Reset behaviour: set `rst_n`=0 for 2 cycles, then release → every output is 0 and `busy`=0. Then pulse `start_conv` → `sample` is high for 2 cycles.
- Basic conversion: comparator model with Vin code 0xA5C, pulse `start_conv` → `conv_done` rises after edge n+14 and `result`=0xA5C. The `dac_word` sequence starts 0x800, 0xC00, 0xA00.
- Edge cases: input codes 0x000 and 0xFFF → `result`=0x000 and 0xFFF. With code 0xFFF, the last trial word is 0xFFF.
- Ignored starts:
  - a `start_conv` pulse during CONVERT → no restart and exactly one `conv_done`;
  - `start_conv` held high for 40 cycles → exactly one conversion.
- Reset mid-operation: assert `rst_n`=0 at cycle n+7 → `ena_out`, `busy` and `dac_word` go to 0 on that edge and there is no `conv_done`.
- Averaging, with `ADC_SAR_AVG_EN`: codes 100, 101, 102, 103 over the four conversions → a single `conv_done` after 4×14+3 cycles, `result`=101, and `ena_out` continuously high.
